// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit behind a start/done handshake.
// Shift-add multiplier and restoring divider share one 2*XLEN working register.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic [XLEN-1:0]   b_mag_q, b_mag_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_by_zero, div_ovf;
  logic [XLEN:0]     mul_sum, rem_sh, trial;
  logic [2*XLEN-1:0] prod_neg;
  logic [XLEN-1:0]   quot_fix, rem_fix, final_val;

  always_comb begin
    a_signed    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg       = a_signed && op_a[XLEN-1];
    b_neg       = b_signed && op_b[XLEN-1];
    a_mag       = a_neg ? ({XLEN{1'b0}} - op_a) : op_a;
    b_mag       = b_neg ? ({XLEN{1'b0}} - op_b) : op_b;
    div_by_zero = funct3[2] && (op_b == '0);
    div_ovf     = funct3[2] && !funct3[0] &&
                  (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
  end

  // Upper half of prod_q is the accumulator/remainder, lower half the multiplier/dividend.
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, b_mag_q} : '0);
    rem_sh   = prod_q[2*XLEN-1:XLEN-1];
    trial    = rem_sh - {1'b0, b_mag_q};
    prod_neg = {(2*XLEN){1'b0}} - prod_q;
    quot_fix = (sign_a_q ^ sign_b_q) ? ({XLEN{1'b0}} - prod_q[XLEN-1:0]) : prod_q[XLEN-1:0];
    rem_fix  = sign_a_q ? ({XLEN{1'b0}} - prod_q[2*XLEN-1:XLEN]) : prod_q[2*XLEN-1:XLEN];
    case (funct3_q)
      3'b000:                 final_val = (sign_a_q ^ sign_b_q) ? prod_neg[XLEN-1:0]
                                                                : prod_q[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_val = (sign_a_q ^ sign_b_q) ? prod_neg[2*XLEN-1:XLEN]
                                                                : prod_q[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_val = quot_fix;
      default:                final_val = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    b_mag_d  = b_mag_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    if (flush) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            funct3_d = funct3;
            sign_a_d = a_neg;
            sign_b_d = b_neg;
            b_mag_d  = b_mag;
            prod_d   = {{XLEN{1'b0}}, a_mag};
            cnt_d    = CW'(XLEN - 1);
            busy_d   = 1'b1;
            if (div_by_zero) begin
              state_d  = S_DONE;
              done_d   = 1'b1;
              result_d = funct3[1] ? op_a : '1;
            end else if (div_ovf) begin
              state_d  = S_DONE;
              done_d   = 1'b1;
              result_d = funct3[1] ? '0 : op_a;
            end else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          if (funct3_q[2]) begin
            prod_d = trial[XLEN] ? {rem_sh[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                                 : {trial[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
          end else begin
            prod_d = {mul_sum, prod_q[XLEN-1:1]};
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) state_d = S_FIX;
        end
        S_FIX: begin
          result_d = final_val;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
        S_DONE: begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      funct3_q <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_mag_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      b_mag_q  <= b_mag_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // A flush arriving in the DONE cycle must hide the pulse from the pipeline.
  assign done   = done_q && !flush;
  assign busy   = busy_q;
  assign result = result_q;

endmodule
